ysyx_24100012_ifu: RTL and testbench



---
 rtl/ysyx_24100012_ifu.sv | 117 +++++++++++
 tb/tb_ysyx_24100012_ifu.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100012_ifu.sv
// Instruction fetch unit: one outstanding word fetch at a time, result held for the
// decoder behind a valid/ready handshake, with redirect squashing and halt.
module ysyx_24100012_ifu #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_req_valid,
  output logic [DATA_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  input  logic                  mem_rsp_err,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [DATA_WIDTH-1:0] inst_pc,
  output logic                  fetch_err,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
  output logic                  halted
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, STOP} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   inst_q, inst_d;
  logic [DATA_WIDTH-1:0]   ipc_q, ipc_d;
  logic                    ferr_q, ferr_d;
  logic                    drop_q, drop_d;
  logic                    hpend_q, hpend_d;   // halt seen with a fetch in flight
  logic                    squash;

  // pc keeps the low bits of a misaligned redirect so the fault can be reported.
  assign mem_req_valid = (state_q == REQ);
  assign mem_req_addr  = {pc_q[DATA_WIDTH-1:2], 2'b00};
  assign inst_valid    = (state_q == HOLD);
  assign halted        = (state_q == STOP);
  assign instruction   = inst_q;
  assign inst_pc       = ipc_q;
  assign fetch_err     = ferr_q;
  assign squash        = drop_q | redirect_valid | halt | hpend_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    ferr_d  = ferr_q;
    drop_d  = drop_q;
    hpend_d = hpend_q;

    if (redirect_valid && state_q != STOP)
      pc_d = redirect_pc;
    else if (state_q == HOLD && inst_ready)
      pc_d = pc_q + DATA_WIDTH'(4);

    case (state_q)
      IDLE: state_d = halt ? STOP : REQ;
      REQ: begin
        if (mem_req_ready) begin
          state_d = WAIT;
          if (redirect_valid || halt) drop_d = 1'b1;
          if (halt) hpend_d = 1'b1;
        end else if (halt) begin
          state_d = STOP;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          if (squash) begin
            drop_d  = 1'b0;
            state_d = (halt || hpend_q) ? STOP : REQ;
          end else begin
            inst_d  = mem_rsp_data;
            ipc_d   = pc_q;
            ferr_d  = mem_rsp_err | (|pc_q[1:0]);
            state_d = HOLD;
          end
        end else begin
          if (redirect_valid || halt) drop_d = 1'b1;
          if (halt) hpend_d = 1'b1;
        end
      end
      HOLD: begin
        if (halt)                           state_d = STOP;
        else if (redirect_valid || inst_ready) state_d = REQ;
      end
      STOP:    state_d = STOP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      ipc_q   <= '0;
      ferr_q  <= 1'b0;
      drop_q  <= 1'b0;
      hpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      ferr_q  <= ferr_d;
      drop_q  <= drop_d;
      hpend_q <= hpend_d;
    end
  end

endmodule

// File: tb/tb_ysyx_24100012_ifu.sv
// Directed + randomized bench for the fetch unit; the reference tracks the PC the
// decoder should see next and the memory image is a fixed function of address.
module tb_ysyx_24100012_ifu;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 0, rst_n = 0;
  logic        mem_req_valid, mem_req_ready = 0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 0, mem_rsp_err = 0;
  logic [31:0] mem_rsp_data = 0;
  logic        inst_valid, inst_ready = 1, fetch_err;
  logic [31:0] instruction, inst_pc;
  logic        redirect_valid = 0, halt = 0, halted;
  logic [31:0] redirect_pc = 0;

  ysyx_24100012_ifu #(.DATA_WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .instruction(instruction),
    .inst_pc(inst_pc), .fetch_err(fetch_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  // memory model state
  bit          pend = 0, rnd = 0;
  int          lat = 0, mem_lat = 0;
  logic [31:0] paddr = 0;
  // reference: PC of the next instruction the decoder should accept
  logic [31:0] exp_pc = RST_PC;
  bit          saw_iv, saw_req, found;
  logic [31:0] k_inst, k_pc;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == RST_PC) ? 32'h0000_0413 : (a ^ 32'h5A5A_3C3C);
  endfunction
  function automatic logic errf(input logic [31:0] a);
    return a[7:2] == 6'h2A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory inputs, take the edge, update memory and reference model.
  task automatic step();
    logic acc, rsp_now, iv, ir, rd, hl, h_err;
    logic [31:0] addr, rpc, h_inst, h_pc, al;
    if (pend && lat == 0) begin
      mem_rsp_valid = 1; mem_rsp_data = word(paddr); mem_rsp_err = errf(paddr);
    end else begin
      mem_rsp_valid = 0; mem_rsp_data = 32'hDEAD_BEEF; mem_rsp_err = 0;
    end
    mem_req_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    acc = mem_req_valid & mem_req_ready; addr = mem_req_addr; rsp_now = mem_rsp_valid;
    iv = inst_valid; ir = inst_ready; rd = redirect_valid; rpc = redirect_pc; hl = halt;
    h_inst = instruction; h_pc = inst_pc; h_err = fetch_err;
    @(posedge clk); #1;
    redirect_valid = 0;
    if (rsp_now) pend = 0;
    else if (pend && lat > 0) lat--;
    if (acc) begin
      chk("one_outstanding", 32'(pend), 0);
      pend = 1; paddr = addr;
      lat = rnd ? $urandom_range(0, 2) : mem_lat;
    end
    if (iv && ir && !rd && !hl) begin
      al = {exp_pc[31:2], 2'b00};
      chk("acc_pc", h_pc, exp_pc);
      chk("acc_inst", h_inst, word(al));
      chk("acc_err", 32'(h_err), 32'(errf(al) | (exp_pc[1:0] != 0)));
      exp_pc = exp_pc + 32'd4;
    end
    if (rd) exp_pc = rpc;
    if (iv && !ir && !rd && !hl) begin
      chk("stall_valid", 32'(inst_valid), 1);
      chk("stall_inst", instruction, h_inst);
    end
  endtask

  task automatic wait_iv(input string tag);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (inst_valid) begin found = 1; break; end
      step();
    end
    chk(tag, 32'(found), 1);
  endtask

  task automatic wait_req(input string tag);
    found = 0; saw_iv = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_valid) begin found = 1; break; end
      step();
      if (inst_valid) saw_iv = 1;
    end
    chk(tag, 32'(found), 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(mem_req_valid), 0);
    chk("rst_req_addr", mem_req_addr, RST_PC);
    chk("rst_inst_valid", 32'(inst_valid), 0);
    chk("rst_instruction", instruction, 0);
    chk("rst_halted", 32'(halted), 0);
    rst_n = 1;

    // boot: zero-wait memory
    step();
    chk("boot_req_valid", 32'(mem_req_valid), 1);
    chk("boot_req_addr", mem_req_addr, RST_PC);
    step();
    chk("boot_wait_iv", 32'(inst_valid), 0);
    step();
    chk("boot_iv", 32'(inst_valid), 1);
    chk("boot_inst", instruction, 32'h0000_0413);
    chk("boot_pc", inst_pc, RST_PC);
    step();
    chk("boot_next_valid", 32'(mem_req_valid), 1);
    chk("boot_next_addr", mem_req_addr, RST_PC + 4);

    // backpressure
    inst_ready = 0;
    wait_iv("bp_wait");
    k_inst = instruction; k_pc = inst_pc;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_pc", inst_pc, k_pc);
      chk("bp_no_req", 32'(mem_req_valid), 0);
    end
    inst_ready = 1;
    step();
    chk("bp_resume_valid", 32'(mem_req_valid), 1);
    chk("bp_resume_addr", mem_req_addr, k_pc + 4);

    // redirect while WAIT, response arrives later and is discarded
    mem_lat = 2;
    step();
    redirect_valid = 1; redirect_pc = 32'h8000_0100;
    step();
    wait_req("rw_req");
    chk("rw_no_iv", 32'(saw_iv), 0);
    chk("rw_addr", mem_req_addr, 32'h8000_0100);

    // redirect in HOLD with inst_ready high
    mem_lat = 0;
    wait_iv("rh_wait");
    redirect_valid = 1; redirect_pc = 32'h8000_0200;
    step();
    chk("rh_iv_drop", 32'(inst_valid), 0);
    chk("rh_req_valid", 32'(mem_req_valid), 1);
    chk("rh_addr", mem_req_addr, 32'h8000_0200);

    // redirect in REQ (accepted same cycle) into a faulting address
    redirect_valid = 1; redirect_pc = 32'h8000_02A8;
    step();
    wait_iv("flt_wait");
    chk("flt_pc", inst_pc, 32'h8000_02A8);
    chk("flt_err", 32'(fetch_err), 1);

    // wrap-around
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    step();
    wait_iv("wrap_wait");
    chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_err", 32'(fetch_err), 0);
    step();
    chk("wrap_addr", mem_req_addr, 32'h0000_0000);

    // misaligned redirect
    redirect_valid = 1; redirect_pc = 32'h8000_0102;
    step();
    wait_req("mis_req");
    chk("mis_addr", mem_req_addr, 32'h8000_0100);
    wait_iv("mis_wait");
    chk("mis_pc", inst_pc, 32'h8000_0102);
    chk("mis_err", 32'(fetch_err), 1);
    chk("mis_inst", instruction, word(32'h8000_0100));

    // randomized traffic, redirects and backpressure against the reference
    rnd = 1;
    for (int i = 0; i < 3000; i++) begin
      inst_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin
        redirect_valid = 1;
        redirect_pc = {16'h8000, 14'($urandom), 2'b00};
      end
      step();
    end
    rnd = 0;
    inst_ready = 1;

    // halt while WAIT
    mem_lat = 2;
    wait_req("halt_req");
    step();
    halt = 1;
    step();
    halt = 0;
    found = 0; saw_iv = 0;
    for (int i = 0; i < 10; i++) begin
      if (halted) begin found = 1; break; end
      step();
      if (inst_valid) saw_iv = 1;
    end
    chk("halt_reached", 32'(found), 1);
    chk("halt_no_iv", 32'(saw_iv), 0);
    saw_req = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (mem_req_valid || inst_valid) saw_req = 1;
    end
    chk("halt_quiet", 32'(saw_req), 0);
    chk("halt_stays", 32'(halted), 1);

    // asynchronous reset clears immediately
    rst_n = 0; pend = 0;
    #1;
    chk("arst_halted", 32'(halted), 0);
    chk("arst_addr", mem_req_addr, RST_PC);
    chk("arst_inst", instruction, 0);
    chk("arst_req", 32'(mem_req_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
